// File: rtl/maj47_bist_ctrl_if.sv
// Bundles the BIST controller's host handshake, result reporting and the
// stimulus/response pair exchanged with the majority block under test.
interface maj47_bist_ctrl_if #(
  parameter int N     = 47,
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_rand;
  logic [N-1:0]     seed;
  logic [N-1:0]     x_out;
  logic             y_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] mismatch_cnt;
  logic [N-1:0]     first_fail_vec;
  logic [CNT_W-1:0] first_fail_idx;
  logic             first_fail_vld;

  // Host side, which also closes the loop through the majority block.
  modport master (
    output start, num_rand, seed, y_in,
    input  x_out, busy, done, pass, mismatch_cnt,
           first_fail_vec, first_fail_idx, first_fail_vld
  );

  // BIST controller side.
  modport slave (
    input  start, num_rand, seed, y_in,
    output x_out, busy, done, pass, mismatch_cnt,
           first_fail_vec, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/maj47_bist_ctrl.sv
// Stimulus generator and golden checker for the 47-input majority block.
// Optional macro MAJ_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module maj47_bist_ctrl #(
  parameter int N          = 47,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 32,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  maj47_bist_ctrl_if.slave  bus
);

  localparam int THRESH  = (N + 1) / 2;
  localparam int PH1_CNT = 2 * N;
  localparam int POP_W   = $clog2(N + 1);
  localparam int K_W     = $clog2(N);
  localparam logic [N-1:0] W_HI = {{(N - THRESH){1'b0}}, {THRESH{1'b1}}};
  localparam logic [N-1:0] W_LO = {{(N - THRESH + 1){1'b0}}, {(THRESH - 1){1'b1}}};

`ifdef MAJ_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       settle_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] num_rand_q;
  logic [N-1:0]     lfsr_q;
  logic [N-1:0]     x_q;
  logic [ERR_W-1:0] err_q;
  logic [N-1:0]     ff_vec_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic             ff_vld_q;

  logic             start_ok, load, mismatch, ref_bit, more_vec, phase1;
  logic [POP_W-1:0] pop;
  logic [CNT_W-1:0] vec_idx;
  logic [K_W-1:0]   k;
  logic [K_W:0]     rsh;
  logic [N-1:0]     base_vec, rot_vec, seed_eff, lfsr_step;
  logic [CNT_W:0]   total_ext, next_ext;
  logic             busy, done, pass;

  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + POP_W'(x_q[i]);
  end

  assign ref_bit  = (pop >= POP_W'(THRESH));
  assign mismatch = (state_q == SAMPLE) && (bus.y_in != ref_bit);

  // Widened by one bit so 94 + num_rand cannot wrap the comparison.
  assign total_ext = (CNT_W+1)'(PH1_CNT) + {1'b0, num_rand_q};
  assign next_ext  = {1'b0, idx_q} + (CNT_W+1)'(1);
  assign more_vec  = (next_ext < total_ext);

  assign vec_idx  = start_ok ? '0 : idx_q + CNT_W'(1);
  assign phase1   = (vec_idx < CNT_W'(PH1_CNT));
  assign k        = vec_idx[K_W:1];
  assign base_vec = vec_idx[0] ? W_LO : W_HI;
  assign rsh      = (K_W+1)'(N) - {1'b0, k};
  assign rot_vec  = (base_vec << k) | (base_vec >> rsh);

  assign seed_eff  = (bus.seed == '0) ? '1 : bus.seed;
  assign lfsr_step = {lfsr_q[N-2:0], lfsr_q[N-1] ^ lfsr_q[N-6]};

  assign load = (state_d == APPLY) && (state_q != APPLY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = APPLY;
      APPLY:      if (settle_q == '0) state_d = SAMPLE;
      SAMPLE: begin
        state_d = more_vec ? APPLY : DONE;
        if (STOP_ON_FAIL && mismatch) state_d = DONE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      APPLY, SAMPLE: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (err_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q   <= '0;
      idx_q      <= '0;
      num_rand_q <= '0;
      lfsr_q     <= '1;
      x_q        <= '0;
      err_q      <= '0;
      ff_vec_q   <= '0;
      ff_idx_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        num_rand_q <= bus.num_rand;
        lfsr_q     <= seed_eff;
        err_q      <= '0;
        ff_vec_q   <= '0;
        ff_idx_q   <= '0;
        ff_vld_q   <= 1'b0;
      end
      if (load) begin
        x_q      <= phase1 ? rot_vec : lfsr_q;
        idx_q    <= vec_idx;
        settle_q <= 4'(SETTLE_CYC - 1);
        if (!phase1) lfsr_q <= lfsr_step;
      end else if (state_q == APPLY && settle_q != '0) begin
        settle_q <= settle_q - 4'd1;
      end
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
        if (!ff_vld_q) begin
          ff_vec_q <= x_q;
          ff_idx_q <= idx_q;
          ff_vld_q <= 1'b1;
        end
      end
    end
  end

  assign bus.x_out          = x_q;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.mismatch_cnt   = err_q;
  assign bus.first_fail_vec = ff_vec_q;
  assign bus.first_fail_idx = ff_idx_q;
  assign bus.first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_maj47_bist_ctrl.sv
// Directed bench: drives the BIST controller with a behavioural majority
// block whose threshold can be made deliberately wrong.
module tb_maj47_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   thr;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  maj47_bist_ctrl_if #(.N(47), .CNT_W(32), .ERR_W(16)) bus ();

  maj47_bist_ctrl #(.N(47), .SETTLE_CYC(2), .CNT_W(32), .ERR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb bus.y_in = ($countones(bus.x_out) >= thr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] nr, input logic [46:0] sd);
    bus.num_rand = nr;
    bus.seed     = sd;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
    $display("start num_rand=%0d seed=%0h", nr, sd);
  endtask

  task automatic wait_done(input int exp, input string tag);
    int n = 0;
    while (!bus.done && n < exp + 20) begin
      tick(1);
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"},    bus.x_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_err"},  bus.mismatch_cnt, 0);
    check({tag, "_fvld"}, bus.first_fail_vld, 0);
    check({tag, "_fvec"}, bus.first_fail_vec, 0);
    check({tag, "_fidx"}, bus.first_fail_idx, 0);
  endtask

  initial begin
    rst = 1'b1;
    thr = 24;
    bus.start = 1'b0;
    bus.num_rand = '0;
    bus.seed = '0;
    tick(2);
    check_zero("rst");
    rst = 1'b0;
    tick(1);

    // Phase 1 only, correct block
    do_start(0, 47'h0);
    check("t1_x0", bus.x_out, 47'h0000_00FF_FFFF);
    check("t1_busy", bus.busy, 1);
    tick(3);
    check("t1_x1", bus.x_out, 47'h0000_007F_FFFF);
    tick(3);
    check("t1_x2", bus.x_out, 47'h0000_01FF_FFFE);
    tick(270);
    check("t1_x92", bus.x_out, 47'h4000_007F_FFFF);
    wait_done(6, "t1_len");
    check("t1_pass", bus.pass, 1);
    check("t1_err", bus.mismatch_cnt, 0);
    check("t1_fvld", bus.first_fail_vld, 0);
    check("t1_busy_end", bus.busy, 0);
    check("t1_xhold", bus.x_out, 47'h4000_003F_FFFF);

    // Phase 2 with seed 1
    do_start(1000, 47'h1);
    tick(282);
    check("t2_x94", bus.x_out, 47'h1);
    tick(3);
    check("t2_x95", bus.x_out, 47'h2);
    wait_done(2997, "t2_len");
    check("t2_pass", bus.pass, 1);
    check("t2_err", bus.mismatch_cnt, 0);

    // Faulty block: threshold 23
    thr = 23;
    do_start(0, 47'h0);
    tick(3);
    check("t3_fvld0", bus.first_fail_vld, 0);
    tick(3);
    check("t3_fvld1", bus.first_fail_vld, 1);
    check("t3_fidx", bus.first_fail_idx, 1);
    check("t3_fvec", bus.first_fail_vec, 47'h0000_007F_FFFF);
`ifdef MAJ_BIST_STOP_ON_FAIL_EN
    check("t3_done", bus.done, 1);
    check("t3_err", bus.mismatch_cnt, 1);
    check("t3_pass", bus.pass, 0);
    check("t3_xfrz", bus.x_out, 47'h0000_007F_FFFF);
`else
    wait_done(276, "t3_len");
    check("t3_err", bus.mismatch_cnt, 47);
    check("t3_pass", bus.pass, 0);
    check("t3_fidx_end", bus.first_fail_idx, 1);
`endif

    // Reset mid-run at vector 50
    do_start(0, 47'h0);
`ifdef MAJ_BIST_STOP_ON_FAIL_EN
    tick(6);
    check("t4_err_mid", bus.mismatch_cnt, 1);
`else
    tick(150);
    check("t4_err_mid", bus.mismatch_cnt, 25);
`endif
    #1;
    rst = 1'b1;
    #1;
    check_zero("t4_rst");
    tick(2);
    rst = 1'b0;
    thr = 24;
    do_start(0, 47'h0);
    check("t4_x0", bus.x_out, 47'h0000_00FF_FFFF);
    check("t4_idx_busy", bus.busy, 1);
    tick(3);
    check("t4_x1", bus.x_out, 47'h0000_007F_FFFF);
    wait_done(279, "t4_len");
    check("t4_pass", bus.pass, 1);
    check("t4_fvld", bus.first_fail_vld, 0);

    // start while busy is ignored
    do_start(0, 47'h0);
    tick(10);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("t5_x3", bus.x_out, 47'h0000_00FF_FFFE);
    wait_done(271, "t5_len");
    check("t5_pass", bus.pass, 1);

    // Zero seed replaced by all-ones
    do_start(2, 47'h0);
    tick(282);
    check("t6_x94", bus.x_out, 47'h7FFF_FFFF_FFFF);
    tick(3);
    check("t6_x95", bus.x_out, 47'h7FFF_FFFF_FFFE);
    wait_done(3, "t6_len");
    check("t6_pass", bus.pass, 1);
    check("t6_err", bus.mismatch_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maj47_bist_ctrl.md
Name: maj47_bist_ctrl

Overview:
- Sequential stimulus generator and golden checker for the 47-input combinational majority block (`top`, ports x0..x46, y0).
- Sits directly upstream of that block: drives its 47 inputs from a registered vector, samples y0 after a settle window, and compares y0 against a popcount reference.
- Replaces the infeasible exhaustive 2^47 sweep with boundary-weight vectors plus pseudo-random vectors. Reports a pass/fail summary.

Parameters:
- N, 47, majority input width; the threshold is derived as (N+1)/2 = 24.
- SETTLE_CYC, 2, clock cycles from x_out update to y_in sample, range 1..15.
- CNT_W, 32, width of the random-vector count and of the vector index.
- ERR_W, 16, width of the mismatch counter; the counter saturates.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE, ignored otherwise.
- num_rand  in  CNT_W  number of LFSR vectors for phase 2; captured on start.
- seed  in  N  LFSR seed, captured on start; an all-zero seed is replaced by all-ones.
- x_out  out  N  vector to the DUT, x_out[i] to xi; registered.
- y_in  in  1  DUT output y0.
- busy  out  1  high in APPLY and SAMPLE.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  valid while done=1: 1 if mismatch_cnt==0.
- mismatch_cnt  out  ERR_W  saturating count of failed compares.
- first_fail_vec  out  N  x_out value at the first mismatch.
- first_fail_idx  out  CNT_W  vector index (0-based, across both phases) of the first mismatch.
- first_fail_vld  out  1  set on the first mismatch; cleared on start.

Behaviour:
- Reset (async, any state): state=IDLE and all outputs 0 (x_out, busy, done, pass, mismatch_cnt, first_fail_*). LFSR=all-ones. Internal counters=0.
- Reset mid-run aborts immediately. No partial result is retained.

States:
- IDLE --start--> APPLY.
- APPLY: x_out <= next vector; settle counter loaded with SETTLE_CYC-1; -> SAMPLE once the counter reaches 0.
- SAMPLE: exactly 1 cycle.
  - Compare y_in against ref = (popcount(x_out) >= 24).
  - On a mismatch: mismatch_cnt++ (saturating at 2^ERR_W-1). If first_fail_vld==0, capture first_fail_vec, first_fail_idx and set first_fail_vld.
  - Go to APPLY if vectors remain, else DONE.
- DONE --start--> APPLY.
- On start: clear the counters and first_fail_*; recapture num_rand and seed.

Timing: vector k is applied on the APPLY edge and sampled SETTLE_CYC cycles later. Throughput is one vector per SETTLE_CYC+1 cycles.

Popcount:
- 6-bit sum, computed combinationally from registered x_out.
- Evaluated only in SAMPLE.

Phase 1 (boundary), 2N = 94 vectors, index 0..93:
- Even index 2k: the low 24 bits set, rotated left by k. Weight is 24, ref=1.
- Odd index 2k+1: the low 23 bits set, rotated left by k. Weight is 23, ref=0.
- k runs 0..46.

Phase 2 (random):
- num_rand vectors; indices continue from 94.
- Generated by a Fibonacci LFSR with polynomial x^47+x^42+1, advancing once per APPLY. The first vector is the seed itself.
- num_rand=0: go to DONE straight after index 93.

Other rules:
- Total vectors = 94 + num_rand; the index must not overflow CNT_W.
- start asserted during APPLY or SAMPLE is ignored. No queuing.
- In DONE, x_out holds the last vector.

Optional Feature:
- MAJ_BIST_STOP_ON_FAIL_EN defined: the first mismatch moves SAMPLE directly to DONE, with mismatch_cnt=1, pass=0, and x_out frozen at the failing vector.
- Macro undefined: the run always completes all vectors and counts every mismatch.

Test Plan:
- Correct majority DUT, SETTLE_CYC=2, num_rand=0, start pulse -> done after 94*3 cycles; pass=1, mismatch_cnt=0, first_fail_vld=0. x_out at index 0 = 47'h0000_00FF_FFFF.
- Correct DUT, num_rand=1000, seed=47'h1 -> done after 1094 vectors; pass=1. The first phase-2 x_out equals 47'h1.
- DUT model with threshold 23 (wrong), num_rand=0 -> mismatch_cnt=47 (every odd vector fails); first_fail_idx=1, first_fail_vec=47'h0000_007F_FFFF.
- Same faulty DUT with MAJ_BIST_STOP_ON_FAIL_EN -> DONE right after index 1; mismatch_cnt=1, pass=0.
- rst asserted at vector 50 -> all outputs 0 at once. A new start with num_rand=0 then runs cleanly, with the index restarting at 0.
- start pulsed while busy=1 -> ignored, run length unchanged. seed=0 -> the first phase-2 vector is all-ones (47'h7FFF_FFFF_FFFF); ref=1.
